// File: rtl/pipe_adder_nbit.sv
// pipe_adder_nbit: STAGES-deep chunked ripple adder with valid/ready flow control.
// Define PIPE_ADDER_SUB_EN to add a sub port selecting a + ~b + 1.
module pipe_adder_nbit #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic         sub,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] S,
  output logic         c,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int W = N / STAGES;
  localparam int L = STAGES - 1;
  logic [N-1:0] ar [STAGES];
  logic [N-1:0] br [STAGES];
  logic [N-1:0] sr [STAGES];
  logic         cr [STAGES];
  logic         v  [STAGES];
  logic [N-1:0] ia [STAGES];
  logic [N-1:0] ib [STAGES];
  logic [N-1:0] is [STAGES];
  logic [N-1:0] ns [STAGES];
  logic         ic [STAGES];
  logic         iv [STAGES];
  logic         nc [STAGES];
  logic [W:0]   t;
  logic [N-1:0] b0;
  logic         c0;
  logic         nov;
  logic         adv;
`ifdef PIPE_ADDER_SUB_EN
  assign b0 = sub ? ~b : b;
  assign c0 = sub ? 1'b1 : cin;
`else
  assign b0 = b;
  assign c0 = cin;
`endif
  assign adv       = !v[L] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v[L];
  assign S         = sr[L];
  assign c         = cr[L];
  // Each stage sees the previous stage's registers; stage 0 sees the ports.
  always_comb begin
    t     = '0;
    ia[0] = a;
    ib[0] = b0;
    is[0] = '0;
    ic[0] = c0;
    iv[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      ia[k] = ar[k-1];
      ib[k] = br[k-1];
      is[k] = sr[k-1];
      ic[k] = cr[k-1];
      iv[k] = v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, ia[k][k*W +: W]} + {1'b0, ib[k][k*W +: W]} + {{W{1'b0}}, ic[k]};
      ns[k] = is[k];
      ns[k][k*W +: W] = t[W-1:0];
      nc[k] = t[W];
    end
    nov = (ia[L][N-1] == ib[L][N-1]) && (ns[L][N-1] != ia[L][N-1]);
  end
  // Data registers load only with a valid token so bubbles cause no toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v[k]  <= 1'b0;
        cr[k] <= 1'b0;
        ar[k] <= '0;
        br[k] <= '0;
        sr[k] <= '0;
      end
      ovf <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v[k] <= iv[k];
        if (iv[k]) begin
          ar[k] <= ia[k];
          br[k] <= ib[k];
          sr[k] <= ns[k];
          cr[k] <= nc[k];
        end
      end
      if (iv[L]) ovf <= nov;
    end
  end
endmodule
